// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing constants, the 12-bit colour type,
// renderer states and colour modes. Imported by the pattern renderer and its
// frame-rate controller.
package vga_pkg;

  // 640x480 @ 60 Hz timing, 25 MHz pixel clock
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } render_state_t;

  typedef enum logic [1:0] {
    MODE_GRAD_BAND = 2'd0,  // gradient shown only inside the band
    MODE_WHITE     = 2'd1,  // white band on black
    MODE_GRAD_INV  = 2'd2,  // full gradient, band inverted
    MODE_SOLID     = 2'd3   // solid colour band on black
  } colour_mode_t;

endpackage

// File: rtl/frame_offset_ctrl.sv
// Frame-rate controller for the line pattern renderer.
// Detects the start of vertical sync (registered vs 1->0), and only on that
// event updates the run/hold/idle state, latches the colour mode and advances
// the scrolling band offset (modulo WRAP).
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   vs_in             vertical sync from timing stage, active-low
//   enable, freeze    control, sampled at the frame event
//   mode              colour mode, sampled at the frame event
//   state             current render state
//   mode_q            colour mode in force for this frame
//   offset            band offset, 0..WRAP-1 (11 bits, top bit always 0)
module frame_offset_ctrl
  import vga_pkg::*;
#(
  parameter int WRAP = 640,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs_in,
  input  logic          enable,
  input  logic          freeze,
  input  logic [1:0]    mode,
  output render_state_t state,
  output colour_mode_t  mode_q,
  output logic [10:0]   offset
);

  logic          vs_prev_reg;
  logic          frame_evt;
  logic [10:0]   offset_reg;
  logic [10:0]   sum;
  logic [10:0]   offset_next;
  render_state_t state_reg;
  colour_mode_t  mode_reg;

  // One-cycle pulse on the falling edge of vsync
  assign frame_evt = vs_prev_reg & ~vs_in;

  // offset < WRAP and STEP < WRAP, so a single subtraction always wraps
  always_comb begin
    sum         = offset_reg + 11'(STEP);
    offset_next = (sum >= 11'(WRAP)) ? (sum - 11'(WRAP)) : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_reg <= 1'b1;
      state_reg   <= IDLE;
      offset_reg  <= '0;
      mode_reg    <= MODE_GRAD_BAND;
    end else begin
      vs_prev_reg <= vs_in;
      if (frame_evt) begin
        mode_reg <= colour_mode_t'(mode);
        if (!enable) begin
          state_reg  <= IDLE;
          offset_reg <= '0;
        end else if (freeze) begin
          state_reg <= HOLD;
        end else begin
          // entering or staying in RUN advances the band on this same edge
          state_reg  <= RUN;
          offset_reg <= offset_next;
        end
      end
    end
  end

  assign state  = state_reg;
  assign mode_q = mode_reg;
  assign offset = offset_reg;

endmodule

// File: rtl/line_pattern_renderer.sv
// Pixel source between the VGA timing counter and the VGA pins. Draws a
// diagonal band THICK pixels wide that scrolls STEP pixels per frame, in one of
// four colour modes. Two-stage pipeline: stage 1 registers the timing inputs,
// stage 2 registers the colour; syncs travel through the same two stages.
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   pix_x, pix_y                current pixel coordinates
//   de_in                       active-area flag
//   hs_in, vs_in                syncs from timing, active-low
//   enable, freeze, mode        control, applied at the next frame start
//   VGA_R, VGA_G, VGA_B         pixel colour, 4 bits each
//   VGA_HS_O, VGA_VS_O          syncs aligned with colour, active-low
module line_pattern_renderer #(
  parameter int          H_ACTIVE  = 640,
  parameter int          THICK     = 4,
  parameter int          STEP      = 1,
  parameter logic [11:0] SOLID_RGB = 12'hF80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       de_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       enable,
  input  logic       freeze,
  input  logic [1:0] mode,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS_O,
  output logic       VGA_VS_O
);
  import vga_pkg::*;

  render_state_t state;
  colour_mode_t  mode_q;
  logic [10:0]   offset;

  frame_offset_ctrl #(
    .WRAP (H_ACTIVE),
    .STEP (STEP)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .vs_in  (vs_in),
    .enable (enable),
    .freeze (freeze),
    .mode   (mode),
    .state  (state),
    .mode_q (mode_q),
    .offset (offset)
  );

  // Stage 1: register timing inputs
  logic [9:0] x_s1_reg, y_s1_reg;
  logic       de_s1_reg, hs_s1_reg, vs_s1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_s1_reg  <= '0;
      y_s1_reg  <= '0;
      de_s1_reg <= 1'b0;
      hs_s1_reg <= 1'b1;
      vs_s1_reg <= 1'b1;
    end else begin
      x_s1_reg  <= pix_x;
      y_s1_reg  <= pix_y;
      de_s1_reg <= de_in;
      hs_s1_reg <= hs_in;
      vs_s1_reg <= vs_in;
    end
  end

  // Band membership and colour selection from stage-1 values
  logic [10:0] base;
  logic [10:0] band_end;
  logic        hit;
  rgb444_t     grad;
  rgb444_t     colour_next;

  always_comb begin
    // Rows whose base reaches H_ACTIVE have no visible band
    base     = {1'b0, y_s1_reg} + offset;
    band_end = base + 11'(THICK);
    hit      = ({1'b0, x_s1_reg} >= base) && ({1'b0, x_s1_reg} < band_end);

    grad.r = {x_s1_reg[6:5], y_s1_reg[5:4]};
    grad.g = {x_s1_reg[5:4], y_s1_reg[6:5]};
    grad.b = y_s1_reg[7:4];

    colour_next = '0;
    if (de_s1_reg && (state != IDLE)) begin
      case (mode_q)
        MODE_GRAD_BAND: colour_next = hit ? grad : '0;
        MODE_WHITE:     colour_next = hit ? 12'hFFF : 12'h000;
        MODE_GRAD_INV:  colour_next = hit ? ~grad : grad;
        MODE_SOLID:     colour_next = hit ? SOLID_RGB : 12'h000;
        default:        colour_next = '0;
      endcase
    end
  end

  // Stage 2: register colour and delayed syncs
  rgb444_t rgb_s2_reg;
  logic    hs_s2_reg, vs_s2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_s2_reg <= '0;
      hs_s2_reg  <= 1'b1;
      vs_s2_reg  <= 1'b1;
    end else begin
      rgb_s2_reg <= colour_next;
      hs_s2_reg  <= hs_s1_reg;
      vs_s2_reg  <= vs_s1_reg;
    end
  end

  assign VGA_R    = rgb_s2_reg.r;
  assign VGA_G    = rgb_s2_reg.g;
  assign VGA_B    = rgb_s2_reg.b;
  assign VGA_HS_O = hs_s2_reg;
  assign VGA_VS_O = vs_s2_reg;

endmodule
